bus_sequencer: RTL and testbench

Micro-step control unit for the single-bus datapath. It steps through fetch and execute phases (T0..T7) and decodes the instruction register into one-hot bus-source selects, register load enables, ALU operation and memory strobes. At most one bus source is driven per cycle. It is the only block that drives the source-select inputs of the bus multiplexer and the Rin/load enables of the register file and special registers.

---
 rtl/bus_sequencer_if.sv | 25 ++
 rtl/bus_sequencer.sv | 136 +++++++++++++
 tb/tb_bus_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_sequencer_if.sv
// bus_sequencer_if: control bundle between the micro-step sequencer and the single-bus datapath
interface bus_sequencer_if;
  logic        run;
  logic [31:0] ir;
  logic        mem_ready;
  logic [23:0] bus_src;
  logic [15:0] reg_in;
  logic [7:0]  ld_en;
  logic        inc_pc;
  logic [4:0]  alu_op;
  logic        read;
  logic        write;
  logic        done;
  logic        halted;
  logic        fault;
  logic [3:0]  step;
  modport master (
    input  run, ir, mem_ready,
    output bus_src, reg_in, ld_en, inc_pc, alu_op, read, write, done, halted, fault, step
  );
  modport slave (
    output run, ir, mem_ready,
    input  bus_src, reg_in, ld_en, inc_pc, alu_op, read, write, done, halted, fault, step
  );
endinterface

// File: rtl/bus_sequencer.sv
// bus_sequencer: T0-T7 fetch/execute micro-step controller for the single-bus datapath
module bus_sequencer #(
  parameter int WAIT_MAX = 15
) (
  input logic             clock,
  input logic             clear,
  bus_sequencer_if.master bus
);
  typedef enum logic [3:0] {
    T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3, T4 = 4'd4, T5 = 4'd5, T6 = 4'd6, T7 = 4'd7,
    IDLE = 4'd8, HALT = 4'd9
  } state_t;
  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [23:0] S_ZH = 24'h040000, S_ZL = 24'h080000, S_PC = 24'h100000;
  localparam logic [23:0] S_MDR = 24'h200000, S_CSE = 24'h800000;
  localparam logic [7:0] L_PC = 8'h80, L_IR = 8'h40, L_MAR = 8'h20, L_MDR = 8'h10;
  localparam logic [7:0] L_Y = 8'h08, L_Z = 8'h04, L_LO = 8'h02, L_HI = 8'h01;
  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic          fault_q, timeout, mem_step, last;
  logic [4:0]    op;
  logic [15:0]   ra_oh, rb_oh, rc_oh;
  logic          is_ld, is_st, is_ialu, is_alu, is_mul, is_halt, is_nop, ir_unused;
  logic [23:0]   src;
  logic [15:0]   rin;
  logic [7:0]    ldv;
  logic [4:0]    aop;
  logic          inc, rd, wr;
  assign op        = bus.ir[31:27];
  assign ra_oh     = 16'd1 << bus.ir[26:23];
  assign rb_oh     = 16'd1 << bus.ir[22:19];
  assign rc_oh     = 16'd1 << bus.ir[18:15];
  assign ir_unused = ^bus.ir[14:0];
  assign is_ld     = op == 5'd0;
  assign is_st     = op == 5'd2;
  assign is_ialu   = op >= 5'd13 && op <= 5'd15;
  assign is_alu    = op >= 5'd3 && op <= 5'd15;
  assign is_mul    = op == 5'd16;
  assign is_halt   = op == 5'd26;
  assign is_nop    = !(is_ld || is_st || is_alu || is_mul || is_halt);
  assign mem_step  = state == T1 || (state == T6 && is_ld) || (state == T7 && is_st);
  assign timeout   = mem_step && !bus.mem_ready && cnt == CW'(WAIT_MAX - 1);
  assign last      = (state == T3 && is_nop) || (state == T5 && is_alu) || (state == T6 && is_mul) ||
                     (state == T7 && is_ld) || (state == T7 && is_st && bus.mem_ready);
  // step sequencing; the last step of any instruction chains straight into the next fetch
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = bus.run ? T0 : IDLE;
      T0:      nxt = T1;
      T1:      nxt = bus.mem_ready ? T2 : timeout ? HALT : T1;
      T2:      nxt = T3;
      T3:      nxt = is_halt ? HALT : T4;
      T4:      nxt = T5;
      T5:      nxt = T6;
      T6:      nxt = (is_ld && !bus.mem_ready) ? (timeout ? HALT : T6) : T7;
      T7:      nxt = (is_st && !bus.mem_ready) ? (timeout ? HALT : T7) : IDLE;
      default: nxt = HALT;
    endcase
    if (last) nxt = bus.run ? T0 : IDLE;
  end
  // state, wait counter and sticky fault; clear wins asynchronously
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state   <= IDLE;
      cnt     <= '0;
      fault_q <= 1'b0;
    end else begin
      state   <= nxt;
      cnt     <= (mem_step && nxt == state) ? cnt + 1'b1 : '0;
      fault_q <= fault_q | timeout;
    end
  end
  // per-step control decode; only mdr_in/done look at mem_ready directly
  always_comb begin
    src = '0;
    rin = '0;
    ldv = '0;
    aop = '0;
    inc = 1'b0;
    rd  = 1'b0;
    wr  = 1'b0;
    case (state)
      T0: begin
        src = S_PC;
        ldv = L_MAR | L_Z;
        inc = 1'b1;
      end
      T1: begin
        src = S_ZL;
        ldv = (cnt == '0 ? L_PC : 8'h0) | (bus.mem_ready ? L_MDR : 8'h0);
        rd  = 1'b1;
      end
      T2: begin
        src = S_MDR;
        ldv = L_IR;
      end
      T3: begin
        src = is_mul ? {8'd0, ra_oh} : (is_alu || is_ld || is_st) ? {8'd0, rb_oh} : '0;
        ldv = (is_alu || is_mul || is_ld || is_st) ? L_Y : 8'h0;
      end
      T4: begin
        src = is_mul ? {8'd0, rb_oh} : (is_alu && !is_ialu) ? {8'd0, rc_oh} : S_CSE;
        aop = (is_alu || is_mul) ? op : 5'd3;
        ldv = L_Z;
      end
      T5: begin
        src = S_ZL;
        rin = is_alu ? ra_oh : '0;
        ldv = is_mul ? L_LO : is_alu ? 8'h0 : L_MAR;
      end
      T6: begin
        src = is_mul ? S_ZH : is_st ? {8'd0, ra_oh} : '0;
        ldv = is_mul ? L_HI : (is_st || bus.mem_ready) ? L_MDR : 8'h0;
        rd  = is_ld;
      end
      T7: begin
        src = is_ld ? S_MDR : '0;
        rin = is_ld ? ra_oh : '0;
        wr  = is_st;
      end
      default: ;
    endcase
  end
  assign bus.bus_src = src;
  assign bus.reg_in  = rin;
  assign bus.ld_en   = ldv;
  assign bus.alu_op  = aop;
  assign bus.inc_pc  = inc;
  assign bus.read    = rd;
  assign bus.write   = wr;
  assign bus.done    = last;
  assign bus.halted  = state == HALT || (state == T3 && is_halt);
  assign bus.fault   = fault_q;
  assign bus.step    = state;
endmodule

// File: tb/tb_bus_sequencer.sv
// tb_bus_sequencer: directed vector and corner-sequence bench for bus_sequencer
module tb_bus_sequencer;
  logic clock = 1'b0;
  logic clear = 1'b1;
  bus_sequencer_if bus ();
  bus_sequencer #(.WAIT_MAX(15)) dut (.clock(clock), .clear(clear), .bus(bus));
  always #5 clock = ~clock;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [31:0] ir;
    int          lat;
    logic [23:0] src3;
    logic [23:0] src4;
    logic [4:0]  alu4;
    logic [23:0] src_last;
    logic [15:0] reg_last;
    logic [7:0]  ld_last;
  } vec_t;
  vec_t vecs[11];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'd0};
  endfunction
  task automatic do_reset();
    @(negedge clock);
    clear = 1'b0;
    bus.run = 1'b0;
    bus.mem_ready = 1'b0;
    bus.ir = '0;
    @(negedge clock);
    clear = 1'b1;
    #1;
  endtask
  task automatic run_vec(input vec_t v, input int i);
    int waits = 0;
    int n = 1;
    logic [23:0] s3 = '0;
    logic [23:0] s4 = '0;
    logic [4:0] a4 = '0;
    while (bus.step != 4'd0 && waits < 20) begin
      @(negedge clock);
      #1;
      waits++;
    end
    check($sformatf("v%0d_t0", i), bus.step, 4'd0);
    if (i > 0) check($sformatf("v%0d_no_bubble", i), waits, 1);
    bus.ir = v.ir;
    while (!bus.done && n < 30) begin
      @(negedge clock);
      #1;
      n++;
      if (bus.step == 4'd3) s3 = bus.bus_src;
      if (bus.step == 4'd4) begin
        s4 = bus.bus_src;
        a4 = bus.alu_op;
      end
    end
    check($sformatf("v%0d_latency", i), n, v.lat);
    check($sformatf("v%0d_src_t3", i), s3, v.src3);
    check($sformatf("v%0d_src_t4", i), s4, v.src4);
    check($sformatf("v%0d_alu_t4", i), a4, v.alu4);
    check($sformatf("v%0d_src_last", i), bus.bus_src, v.src_last);
    check($sformatf("v%0d_reg_last", i), bus.reg_in, v.reg_last);
    check($sformatf("v%0d_ld_last", i), bus.ld_en, v.ld_last);
  endtask
  initial begin
    int rd_cnt, mdr_cnt, mdr_at, t6, wr_cnt, dn, not9, h2, k;
    bus.run = 1'b0;
    bus.mem_ready = 1'b0;
    bus.ir = '0;
    vecs[0]  = '{enc(5'd3, 4'd3, 4'd1, 4'd2),   6, 24'h000002, 24'h000004, 5'd3,  24'h080000, 16'h0008, 8'h00};
    vecs[1]  = '{enc(5'd12, 4'd15, 4'd14, 4'd0), 6, 24'h004000, 24'h000001, 5'd12, 24'h080000, 16'h8000, 8'h00};
    vecs[2]  = '{enc(5'd13, 4'd5, 4'd4, 4'd9),   6, 24'h000010, 24'h800000, 5'd13, 24'h080000, 16'h0020, 8'h00};
    vecs[3]  = '{enc(5'd15, 4'd0, 4'd0, 4'd0),   6, 24'h000001, 24'h800000, 5'd15, 24'h080000, 16'h0001, 8'h00};
    vecs[4]  = '{enc(5'd16, 4'd2, 4'd7, 4'd0),   7, 24'h000004, 24'h000080, 5'd16, 24'h040000, 16'h0000, 8'h01};
    vecs[5]  = '{enc(5'd0, 4'd1, 4'd2, 4'd0) | 32'd5, 8, 24'h000004, 24'h800000, 5'd3, 24'h200000, 16'h0002, 8'h00};
    vecs[6]  = '{enc(5'd2, 4'd4, 4'd6, 4'd0),    8, 24'h000040, 24'h800000, 5'd3,  24'h000000, 16'h0000, 8'h00};
    vecs[7]  = '{enc(5'd31, 4'd3, 4'd3, 4'd3),   4, 24'h000000, 24'h000000, 5'd0,  24'h000000, 16'h0000, 8'h00};
    vecs[8]  = '{enc(5'd1, 4'd9, 4'd9, 4'd9),    4, 24'h000000, 24'h000000, 5'd0,  24'h000000, 16'h0000, 8'h00};
    vecs[9]  = '{enc(5'd17, 4'd1, 4'd1, 4'd1),   4, 24'h000000, 24'h000000, 5'd0,  24'h000000, 16'h0000, 8'h00};
    vecs[10] = '{enc(5'd25, 4'd2, 4'd2, 4'd2),   4, 24'h000000, 24'h000000, 5'd0,  24'h000000, 16'h0000, 8'h00};
    #2 clear = 1'b0;
    #1;
    check("rst_step", bus.step, 4'd8);
    check("rst_outs", {bus.bus_src, bus.reg_in, bus.ld_en, bus.alu_op, bus.inc_pc, bus.read, bus.write, bus.done, bus.halted, bus.fault}, 64'd0);
    @(negedge clock);
    clear = 1'b1;
    #1;
    check("idle_step", bus.step, 4'd8);
    bus.run = 1'b1;
    @(negedge clock);
    #1;
    check("t0_step", bus.step, 4'd0);
    check("t0_ctrl", {bus.bus_src, bus.ld_en, bus.inc_pc}, {24'h100000, 8'h24, 1'b1});
    @(negedge clock);
    #1;
    check("t1_first", {bus.bus_src, bus.ld_en, bus.read}, {24'h080000, 8'h80, 1'b1});
    @(negedge clock);
    #1;
    check("t1_wait", {bus.step, bus.ld_en, bus.read}, {4'd1, 8'h00, 1'b1});
    bus.mem_ready = 1'b1;
    #1;
    check("t1_ready_mdr", bus.ld_en, 8'h10);
    bus.mem_ready = 1'b0;
    #1;
    clear = 1'b0;
    #1;
    check("midfetch_clear", {bus.step, bus.read, bus.bus_src, bus.ld_en}, {4'd8, 1'b0, 24'h0, 8'h0});
    do_reset();
    bus.run = 1'b1;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);
    do_reset();
    bus.run = 1'b1;
    bus.mem_ready = 1'b1;
    bus.ir = enc(5'd0, 4'd1, 4'd2, 4'd0) | 32'd5;
    rd_cnt = 0;
    mdr_cnt = 0;
    mdr_at = 0;
    t6 = 0;
    k = 0;
    while (k < 40 && bus.step != 4'd7) begin
      @(negedge clock);
      bus.mem_ready = !(bus.step == 4'd6 && t6 < 3);
      #1;
      if (bus.step == 4'd6) begin
        t6++;
        rd_cnt += int'(bus.read);
        if (bus.ld_en[4]) begin
          mdr_cnt++;
          mdr_at = t6;
        end
      end
      k++;
    end
    check("ld_read_cycles", rd_cnt, 4);
    check("ld_mdr_count", mdr_cnt, 1);
    check("ld_mdr_last", mdr_at, 4);
    check("ld_t7_reg", {bus.step, bus.reg_in, bus.done}, {4'd7, 16'h0002, 1'b1});
    do_reset();
    bus.run = 1'b1;
    bus.ir = enc(5'd2, 4'd4, 4'd6, 4'd0);
    wr_cnt = 0;
    k = 0;
    while (k < 80 && bus.step != 4'd9) begin
      @(negedge clock);
      bus.mem_ready = bus.step != 4'd7;
      #1;
      if (bus.step == 4'd7 && bus.write) wr_cnt++;
      k++;
    end
    check("st_write_cycles", wr_cnt, 15);
    check("st_timeout", {bus.step, bus.fault, bus.halted, bus.write, bus.read, bus.done}, {4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    check("st_halt_bus", {bus.bus_src, bus.ld_en}, 32'd0);
    not9 = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clock);
      bus.run = j[0];
      bus.mem_ready = 1'b1;
      #1;
      if (bus.step != 4'd9 || !bus.fault) not9++;
    end
    check("st_stays_halted", not9, 0);
    do_reset();
    bus.run = 1'b1;
    bus.mem_ready = 1'b1;
    bus.ir = enc(5'd26, 4'd0, 4'd0, 4'd0);
    h2 = 1;
    k = 0;
    while (k < 20 && bus.step != 4'd3) begin
      @(negedge clock);
      #1;
      if (bus.step == 4'd2) h2 = int'(bus.halted);
      k++;
    end
    check("halt_low_t2", h2, 0);
    check("halt_t3", {bus.step, bus.halted, bus.done, bus.fault}, {4'd3, 1'b1, 1'b0, 1'b0});
    dn = 0;
    not9 = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clock);
      bus.run = ~bus.run;
      #1;
      dn += int'(bus.done);
      if (bus.step != 4'd9 || !bus.halted || bus.fault) not9++;
    end
    check("halt_no_done", dn, 0);
    check("halt_stays", not9, 0);
    do_reset();
    bus.run = 1'b1;
    for (int j = 0; j < 400; j++) begin
      @(negedge clock);
      bus.mem_ready = $urandom_range(0, 3) != 0;
      if (bus.step == 4'd0) bus.ir = {$urandom_range(0, 31) == 0 ? 5'd26 : 5'($urandom_range(0, 17)), 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom)};
      #1;
      check("rand_src_onehot", $onehot0(bus.bus_src), 1'b1);
      check("rand_reg_onehot", $onehot0(bus.reg_in), 1'b1);
      if (bus.step == 4'd9) begin
        clear = 1'b0;
        #1;
        clear = 1'b1;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
